// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score overlay controller
package score_pkg;

   localparam int SCORE_W = 3;
   localparam int SCORE_H = 5;

   // Row-major bitmap, top row in the MSBs, leftmost column first within a row.
   typedef logic [SCORE_W*SCORE_H-1:0] score_t;

   typedef logic [3:0] score_cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      SERVE,
      GAME_OVER
   } score_state_t;

   localparam score_t GLYPH_0     = 15'b111_101_101_101_111;
   localparam score_t GLYPH_BLANK = '0;

endpackage

// File: rtl/score_font.sv
// rtl/score_font.sv - combinational 3x5 digit font ROM, digits 0..9, blank above 9
module score_font
   import score_pkg::*;
(
   input  logic [3:0] digit,
   output score_t     glyph
);

   always_comb begin
      glyph = GLYPH_BLANK;
      case (digit)
         4'd0:    glyph = GLYPH_0;
         4'd1:    glyph = 15'b010_110_010_010_111;
         4'd2:    glyph = 15'b111_001_111_100_111;
         4'd3:    glyph = 15'b111_001_111_001_111;
         4'd4:    glyph = 15'b101_101_111_001_001;
         4'd5:    glyph = 15'b111_100_111_001_111;
         4'd6:    glyph = 15'b111_100_111_101_111;
         4'd7:    glyph = 15'b111_001_001_001_001;
         4'd8:    glyph = 15'b111_101_111_101_111;
         4'd9:    glyph = 15'b111_101_111_001_111;
         default: glyph = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - goal counting, round FSM and frame-synchronous glyph outputs
// Optional winner-glyph blink in GAME_OVER is built when SCORE_BLINK_EN is defined.
module score_ctrl
   import score_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60
`ifdef SCORE_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 16
`endif
)(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   frame_tick_i,
   input  logic   start_i,
   input  logic   player_goal_i,
   input  logic   enemy_goal_i,
   output score_t player_score_o,
   output score_t enemy_score_o,
   output logic   ball_freeze_o,
   output logic   serve_dir_o,
   output logic   game_over_o,
   output logic   winner_o
);

   localparam int FW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
   localparam score_cnt_t    WIN_CNT    = score_cnt_t'(WIN_SCORE);

   score_state_t  state_q, state_d;
   score_cnt_t    p_cnt_q, p_cnt_d, e_cnt_q, e_cnt_d;
   score_cnt_t    p_inc, e_inc;
   logic [FW-1:0] frame_q, frame_d;
   logic          dir_q, dir_d;
   logic          winner_q, winner_d;

   score_t        p_font, e_font;
   score_t        p_stage_q, e_stage_q;
   score_t        p_out_q, e_out_q;
   logic          hide_p, hide_e;

   assign p_inc = p_cnt_q + 4'd1;
   assign e_inc = e_cnt_q + 4'd1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         p_cnt_q  <= '0;
         e_cnt_q  <= '0;
         frame_q  <= '0;
         dir_q    <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_cnt_q  <= p_cnt_d;
         e_cnt_q  <= e_cnt_d;
         frame_q  <= frame_d;
         dir_q    <= dir_d;
         winner_q <= winner_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      p_cnt_d  = p_cnt_q;
      e_cnt_d  = e_cnt_q;
      frame_d  = frame_q;
      dir_d    = dir_q;
      winner_d = winner_q;
      case (state_q)
         IDLE, GAME_OVER: begin
            if (start_i) begin
               state_d = PLAY;
               p_cnt_d = '0;
               e_cnt_d = '0;
               dir_d   = 1'b0;
            end
         end
         PLAY: begin
            // Player pulse wins a same-cycle tie; the enemy pulse is simply dropped.
            if (player_goal_i) begin
               p_cnt_d = p_inc;
               dir_d   = 1'b0;
               frame_d = '0;
               if (p_inc == WIN_CNT) begin
                  state_d  = GAME_OVER;
                  winner_d = 1'b1;
               end else begin
                  state_d = SERVE;
               end
            end else if (enemy_goal_i) begin
               e_cnt_d = e_inc;
               dir_d   = 1'b1;
               frame_d = '0;
               if (e_inc == WIN_CNT) begin
                  state_d  = GAME_OVER;
                  winner_d = 1'b0;
               end else begin
                  state_d = SERVE;
               end
            end
         end
         SERVE: begin
            if (frame_tick_i) begin
               if (frame_q == SERVE_LAST) begin
                  state_d = PLAY;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   score_font u_font_player (
      .digit (p_cnt_q),
      .glyph (p_font)
   );

   score_font u_font_enemy (
      .digit (e_cnt_q),
      .glyph (e_font)
   );

`ifdef SCORE_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] blink_cnt_q;
   logic          blink_vis_q;

   // Held at phase zero outside GAME_OVER so every game-over starts visible.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || state_q != GAME_OVER) begin
         blink_cnt_q <= '0;
         blink_vis_q <= 1'b1;
      end else if (frame_tick_i) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_vis_q <= ~blink_vis_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   assign hide_p = (state_q == GAME_OVER) &&  winner_q && !blink_vis_q;
   assign hide_e = (state_q == GAME_OVER) && !winner_q && !blink_vis_q;
`else
   assign hide_p = 1'b0;
   assign hide_e = 1'b0;
`endif

   // Staging follows the counters every cycle; the renderer-facing copy moves only on a frame tick.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         p_stage_q <= GLYPH_0;
         e_stage_q <= GLYPH_0;
         p_out_q   <= GLYPH_0;
         e_out_q   <= GLYPH_0;
      end else begin
         p_stage_q <= p_font;
         e_stage_q <= e_font;
         if (frame_tick_i) begin
            p_out_q <= hide_p ? GLYPH_BLANK : p_stage_q;
            e_out_q <= hide_e ? GLYPH_BLANK : e_stage_q;
         end
      end
   end

   assign player_score_o = p_out_q;
   assign enemy_score_o  = e_out_q;
   assign ball_freeze_o  = (state_q != PLAY);
   assign serve_dir_o    = dir_q;
   assign game_over_o    = (state_q == GAME_OVER);
   assign winner_o       = (state_q == GAME_OVER) && winner_q;

endmodule
